// File: rtl/pe_dot_seq.sv
// Purpose: sequence a long int16 dot product as 32-lane chunks; sum each chunk's tree output into a running accumulator.
// Latency: in_ready rises 1 cycle after start; an N-chunk job with no stalls raises out_valid at cycle N+1.
// Backpressure: in_valid gaps stall the job with no state change; the result is held stable until out_ready.
// Build option: define PE_DOT_SAT_EN for a saturating accumulate and the sat_flag output.
module pe_dot_seq #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] chunk_num,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      tree_sum,
    output logic [CNT_W-1:0] chunk_cnt,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PE_DOT_SAT_EN
    output logic             sat_flag,
`endif
    output logic [ACC_W-1:0] result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_add;
    logic [CNT_W-1:0]   num_lat;
    logic signed [ACC_W:0] sum_ext;
    logic               fire;
    logic               last_fire;
`ifdef PE_DOT_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic               clamp;
`endif

    assign fire      = in_valid & in_ready;
    assign last_fire = fire && (chunk_cnt == (num_lat - CNT_W'(1)));
    assign result    = acc;

    // One extra bit of headroom so a signed overflow is visible in the top two bits.
    assign sum_ext = $signed({acc[ACC_W-1], acc}) + (ACC_W+1)'(signed'(tree_sum));

    // Next accumulator value: wrap by truncation, or clamp to the signed range when saturation is built in.
    always_comb begin
        acc_add = sum_ext[ACC_W-1:0];
`ifdef PE_DOT_SAT_EN
        clamp = 1'b0;
        if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
            clamp   = 1'b1;
            acc_add = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
        end
`endif
    end

    // Job FSM with registered handshake outputs and accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            chunk_cnt <= '0;
            num_lat   <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
`ifdef PE_DOT_SAT_EN
            sat_flag  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        chunk_cnt <= '0;
                        busy      <= 1'b1;
`ifdef PE_DOT_SAT_EN
                        sat_flag  <= 1'b0;
`endif
                        if (chunk_num != '0) begin
                            num_lat  <= chunk_num;
                            state    <= ST_RUN;
                            in_ready <= 1'b1;
                        end else begin
                            // Empty job: nothing to accumulate, present a zero result immediately.
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        acc       <= acc_add;
                        chunk_cnt <= chunk_cnt + CNT_W'(1);
`ifdef PE_DOT_SAT_EN
                        if (clamp) begin
                            sat_flag <= 1'b1;
                        end
`endif
                        if (last_fire) begin
                            state     <= ST_DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
